// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : axis_pkt_fifo
// Brief    : AXI-Stream beat FIFO with fill level and stored-packet count.
//            Define AXIS_PKT_FIFO_STORE_FWD_EN for store-and-forward output.
// Revision : 1.0
// -----------------------------------------------------------------------------
module axis_pkt_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [CNT_W-1:0]      level,
   output logic [CNT_W-1:0]      pkt_count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [AW:0]         wr_ptr_nxt;
   logic [AW:0]         rd_ptr_nxt;
   logic [CNT_W-1:0]    pkt_nxt;
   logic                push;
   logic                pop;
   logic                full_nxt;
   logic                empty_nxt;
   logic                tvalid_nxt;

   assign push = s_axis_tvalid & s_axis_tready;
   assign pop  = m_axis_tvalid & m_axis_tready;

   // Pointers carry an extra wrap bit, so their difference is the fill level.
   assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
   assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
   assign level      = wr_ptr - rd_ptr;

   assign full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
   assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);

   always_comb begin
      pkt_nxt = pkt_count;
      case ({push & s_axis_tlast, pop & m_axis_tlast})
         2'b10:   pkt_nxt = pkt_count + 1'b1;
         2'b01:   pkt_nxt = pkt_count - 1'b1;
         default: pkt_nxt = pkt_count;
      endcase
   end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
   // A full FIFO is released even without a stored tlast to avoid deadlock.
   assign tvalid_nxt = !empty_nxt && ((pkt_nxt != '0) || full_nxt);
`else
   assign tvalid_nxt = !empty_nxt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         pkt_count     <= '0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else begin
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         pkt_count     <= pkt_nxt;
         s_axis_tready <= !full_nxt;
         m_axis_tvalid <= tvalid_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_fifo.sv
`default_nettype none
// Testbench for axis_pkt_fifo: directed scenarios with a scoreboard on the
// master port that checks order, data and tlast of every popped beat.
module tb_axis_pkt_fifo;

   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [CW-1:0] level;
   logic [CW-1:0] pkt_count;

   int total = 0;
   int bad = 0;
   int n_pop = 0;
   logic [DW:0] sb[$];
   logic        prev_stall = 1'b0;
   logic [DW:0] prev_beat = '0;

   axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .level        (level),
      .pkt_count    (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so at negedge the handshakes
   // that will complete at the next posedge are already settled.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_beat) begin
               bad++;
               $display("FAIL stall_hold got valid=%b beat=%h want valid=1 beat=%h",
                        m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev_beat);
            end
         end
         if (s_axis_tvalid === 1'b1 && s_axis_tready === 1'b1)
            sb.push_back({s_axis_tlast, s_axis_tdata});
         if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            total++;
            n_pop++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_pop got beat=%h want no beat (queue empty)",
                        {m_axis_tlast, m_axis_tdata});
            end else begin
               logic [DW:0] exp_beat;
               exp_beat = sb.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== exp_beat) begin
                  bad++;
                  $display("FAIL sb_beat got %h want %h", {m_axis_tlast, m_axis_tdata}, exp_beat);
               end
            end
         end
         prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
         prev_beat  = {m_axis_tlast, m_axis_tdata};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic l);
      int waitc = 0;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (s_axis_tready !== 1'b1 && waitc < 50) begin
         tick();
         waitc++;
      end
      if (s_axis_tready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL push_timeout got tready=%b want 1", s_axis_tready);
      end else begin
         tick();
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain();
      int waitc = 0;
      m_axis_tready = 1'b1;
      while ((m_axis_tvalid !== 1'b0 || level !== '0) && waitc < 200) begin
         tick();
         waitc++;
      end
      total++;
      if (m_axis_tvalid !== 1'b0 || level !== '0) begin
         bad++;
         $display("FAIL drain_timeout got valid=%b level=%0d want valid=0 level=0",
                  m_axis_tvalid, level);
      end
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_leftover got %0d beats pending want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'h77;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) tick();
      total++;
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold got tready=%b tvalid=%b want 0 0", s_axis_tready, m_axis_tvalid);
      end
      reset = 1'b0;
      #1;
      total++;
      if (s_axis_tready !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_early got tready=%b want 0", s_axis_tready);
      end
      tick();
      total++;
      if (s_axis_tready !== 1'b1 || level !== '0 || pkt_count !== '0 || m_axis_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_after got tready=%b level=%0d pkt=%0d tvalid=%b want 1 0 0 0",
                  s_axis_tready, level, pkt_count, m_axis_tvalid);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [DW-1:0] v;
      logic [DW-1:0] p3;
      int start_pop;
      p3 = 8'd3;
      m_axis_tready = 1'b0;
      start_pop = n_pop;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < 8) begin
            v = 8'd1 << i;
         end else begin
            v = p3;
            p3 = 8'(p3 * 8'd3);
         end
         push_beat(v, 1'b0);
         total++;
         if (level !== CW'(i + 1)) begin
            bad++;
            $display("FAIL fill_level got %0d want %0d", level, i + 1);
         end
      end
      total++;
      if (s_axis_tready !== 1'b0 || level !== CW'(DEPTH) || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'd1) begin
         bad++;
         $display("FAIL full_state got tready=%b level=%0d tvalid=%b head=%h want 0 16 1 01",
                  s_axis_tready, level, m_axis_tvalid, m_axis_tdata);
      end
      // Offer a beat while full and release the sink in the same cycle.
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'hEE;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      tick();
      total++;
      if (level !== CW'(DEPTH - 1) || s_axis_tready !== 1'b1) begin
         bad++;
         $display("FAIL full_pop got level=%0d tready=%b want 15 1", level, s_axis_tready);
      end
      tick();
      total++;
      if (level !== CW'(DEPTH - 1)) begin
         bad++;
         $display("FAIL push_pop_level got %0d want 15", level);
      end
      s_axis_tvalid = 1'b0;
      drain();
      total++;
      if (n_pop - start_pop != DEPTH + 1) begin
         bad++;
         $display("FAIL fill_pop_count got %0d want %0d", n_pop - start_pop, DEPTH + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d = 8'(8'h80 + i);
         s_axis_tdata = d;
         s_axis_tlast = 1'b1;
         s_axis_tvalid = 1'b1;
         tick();
         total++;
         if (level !== CW'(1) || m_axis_tvalid !== 1'b1 || m_axis_tdata !== d) begin
            bad++;
            $display("FAIL b2b_beat%0d got level=%0d tvalid=%b data=%h want 1 1 %h",
                     i, level, m_axis_tvalid, m_axis_tdata, d);
         end
      end
      s_axis_tvalid = 1'b0;
      tick();
      total++;
      if (level !== '0 || m_axis_tvalid !== 1'b0 || pkt_count !== '0) begin
         bad++;
         $display("FAIL b2b_end got level=%0d tvalid=%b pkt=%0d want 0 0 0", level, m_axis_tvalid, pkt_count);
      end
   endtask

   task automatic test_pkt_count();
      int exp_pkt;
      logic exp_last;
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++)
         push_beat(8'(8'h41 + i), (i == 2) || (i == 5));
      total++;
      if (pkt_count !== CW'(2) || level !== CW'(6)) begin
         bad++;
         $display("FAIL pkt_stored got pkt=%0d level=%0d want 2 6", pkt_count, level);
      end
      exp_pkt = 2;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_last = (i == 2) || (i == 5);
         total++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== exp_last || m_axis_tdata !== 8'(8'h41 + i)) begin
            bad++;
            $display("FAIL pkt_head%0d got tvalid=%b tlast=%b data=%h want 1 %b %h",
                     i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, exp_last, 8'(8'h41 + i));
         end
         tick();
         if (exp_last) exp_pkt--;
         total++;
         if (pkt_count !== CW'(exp_pkt)) begin
            bad++;
            $display("FAIL pkt_dec%0d got %0d want %0d", i, pkt_count, exp_pkt);
         end
      end
      drain();
   endtask

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
   task automatic test_store_fwd();
      int start_pop;
      m_axis_tready = 1'b0;
      push_beat(8'hA1, 1'b0);
      push_beat(8'hA2, 1'b0);
      total++;
      if (m_axis_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL sf_partial got tvalid=%b want 0", m_axis_tvalid);
      end
      push_beat(8'hA3, 1'b1);
      total++;
      if (m_axis_tvalid !== 1'b1 || pkt_count !== CW'(1)) begin
         bad++;
         $display("FAIL sf_complete got tvalid=%b pkt=%0d want 1 1", m_axis_tvalid, pkt_count);
      end
      drain();
      m_axis_tready = 1'b0;
      start_pop = n_pop;
      for (int i = 0; i < DEPTH; i++) begin
         push_beat(8'(8'hC0 + i), 1'b0);
         total++;
         if (m_axis_tvalid !== (i == DEPTH - 1)) begin
            bad++;
            $display("FAIL sf_long%0d got tvalid=%b want %b", i, m_axis_tvalid, (i == DEPTH - 1));
         end
      end
      m_axis_tready = 1'b1;
      for (int i = DEPTH; i < 20; i++)
         push_beat(8'(8'hC0 + i), i == 19);
      drain();
      total++;
      if (n_pop - start_pop != 20) begin
         bad++;
         $display("FAIL sf_long_count got %0d want 20", n_pop - start_pop);
      end
   endtask
`else
   task automatic test_cut_through();
      m_axis_tready = 1'b0;
      push_beat(8'hA1, 1'b0);
      total++;
      if (m_axis_tvalid !== 1'b1 || pkt_count !== '0 || m_axis_tdata !== 8'hA1) begin
         bad++;
         $display("FAIL ct_present got tvalid=%b pkt=%0d data=%h want 1 0 a1",
                  m_axis_tvalid, pkt_count, m_axis_tdata);
      end
      drain();
   endtask
`endif

   task automatic test_reset_mid_packet();
      int start_pop;
      m_axis_tready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_beat(8'(8'h10 + i), i == 1);
      total++;
      if (level !== CW'(5) || pkt_count !== CW'(1)) begin
         bad++;
         $display("FAIL mid_pre got level=%0d pkt=%0d want 5 1", level, pkt_count);
      end
      #3;
      reset = 1'b1;
      #1;
      total++;
      if (level !== '0 || pkt_count !== '0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
         bad++;
         $display("FAIL mid_async got level=%0d pkt=%0d tvalid=%b tready=%b want 0 0 0 0",
                  level, pkt_count, m_axis_tvalid, s_axis_tready);
      end
      sb.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale got tvalid=%b want 0", m_axis_tvalid);
         end
      end
      start_pop = n_pop;
      push_beat(8'h5A, 1'b1);
      drain();
      total++;
      if (n_pop - start_pop != 1) begin
         bad++;
         $display("FAIL mid_after_count got %0d want 1", n_pop - start_pop);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_pkt_count();
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      test_store_fwd();
`else
      test_cut_through();
`endif
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
Synchronous AXI-Stream FIFO that sits directly downstream of the 2:1 AXI-Stream mux. It absorbs the mux output and decouples the mux from back-pressure on the final sink. Stores tdata and tlast per beat, and reports its fill level and the number of complete packets it holds.

Parameters:
DATA_WIDTH, 8, width of tdata on both ports.
DEPTH, 16, number of entries; power of 2, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of the level and pkt_count outputs; derived, never overridden.

Ports:
clk  input  1  single clock for all logic.
reset  input  1  asynchronous, active-high reset.
s_axis_tdata  input  DATA_WIDTH  slave data, driven by the mux m_axis_tdata.
s_axis_tvalid  input  1  slave valid.
s_axis_tready  output  1  slave ready; registered.
s_axis_tlast  input  1  slave end-of-packet.
m_axis_tdata  output  DATA_WIDTH  master data, read from the head entry.
m_axis_tvalid  output  1  master valid; registered.
m_axis_tready  input  1  master ready from the sink.
m_axis_tlast  output  1  tlast stored with the head entry.
level  output  CNT_W  number of stored beats, 0..DEPTH.
pkt_count  output  CNT_W  number of stored beats that have tlast=1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - write pointer, read pointer, level and pkt_count = 0.
  - s_axis_tready = 0 and m_axis_tvalid = 0.
  - s_axis_tready rises on the first clk rising edge after reset deasserts.
- Push: s_axis_tvalid && s_axis_tready at a rising edge. The entry at the write pointer takes {tlast, tdata}, and the write pointer increments modulo DEPTH.
- Pop: m_axis_tvalid && m_axis_tready at a rising edge. The read pointer increments modulo DEPTH.
- Pointers carry one extra wrap bit. Full: pointers equal in the low bits, wrap bits differ. Empty: pointers fully equal.
- level updates by push minus pop:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
- s_axis_tready is registered as (next level != DEPTH). It never depends combinationally on m_axis_tready.
- Full with a same-cycle pop: no push that cycle, because tready is already 0. tready returns to 1 on the following edge.
- Empty: m_axis_tvalid = 0, so no pop can occur. A simultaneous push makes m_axis_tvalid 1 after that edge.
- Latency: a beat pushed at edge N appears on m_axis with tvalid=1 after edge N (1 cycle).
- m_axis_tdata and m_axis_tlast are combinational reads of the entry at the read pointer. Their value while tvalid=0 is don't-care.
- m_axis_tvalid never falls without a completed pop. tdata and tlast stay stable while tvalid=1 and tready=0.
- pkt_count:
  - +1 on a push with s_axis_tlast=1.
  - -1 on a pop with m_axis_tlast=1.
  - both in the same cycle: unchanged.
- Ordering is strict: beats leave in arrival order.
- A push offered while s_axis_tready=0 is simply not taken; the upstream holds it.
- Reset asserted mid-packet discards all contents immediately. Partial packets are not preserved.

Optional Feature:
Macro: AXIS_PKT_FIFO_STORE_FWD_EN
- Defined (store-and-forward):
  - m_axis_tvalid = (level != 0) && (pkt_count != 0 || level == DEPTH).
  - A packet is presented only once its tlast beat is stored.
  - The full-FIFO escape prevents deadlock on packets longer than DEPTH. In that case tvalid may drop after a completed pop, mid-packet.
- Undefined (cut-through): m_axis_tvalid = (level != 0).
- pkt_count exists in both builds.

Test Plan:
1. Reset held 3 cycles, then released, with s_axis_tvalid=1 -> s_axis_tready=0 and m_axis_tvalid=0 during reset; tready=1 one edge after release; level=0 and pkt_count=0 before the first push.
2. m_axis_tready=0; push beats 1,2,4,...,128 then 3,9,27,...; DEPTH=16 -> level counts 1..16; s_axis_tready=0 once level=16; then m_axis_tready=1 -> all 16 beats emerge in order with tready back at 1 one edge after the first pop.
3. Continuous push and pop with both readies at 1 -> level holds at 1; output equals input delayed 1 cycle; pointers wrap past entry 15 with no lost or duplicated beat.
4. Two 3-beat packets (tlast on the 3rd beat), sink stalled -> pkt_count=2; release the sink -> pkt_count decrements on each tlast pop; m_axis_tlast=1 exactly on beats 3 and 6.
5. With AXIS_PKT_FIFO_STORE_FWD_EN, push beats 0xA1, 0xA2 without tlast -> m_axis_tvalid stays 0; push 0xA3 with tlast -> m_axis_tvalid=1 the next cycle. Then push a 20-beat packet into DEPTH=16 -> tvalid rises at level=16 and the packet drains.
6. Reset asserted mid-packet with level=5 -> level, pkt_count and m_axis_tvalid are 0 immediately (asynchronously); no stale beat appears after release.
